// File: rtl/axis_frame_packer.sv
// Frames a free-running AXIS sample stream into FRAME_LEN-sample frames with
// tlast, buffers whole frames in a FIFO and drops frames that cannot fit.
// Ports:
//   clk, aresetn (sync, active-low)
//   enable: admission enable, sampled at frame start
//   s_axis_tdata/tvalid: input stream, no backpressure
//   m_axis_tdata/tvalid/tready/tlast: buffered output stream
//   frames_dropped: saturating drop count
//   fifo_level: stored words, including the output register
module axis_frame_packer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int FRAME_LEN        = 256,
  parameter int FIFO_AW          = 10,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic                        enable,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [CNT_WIDTH-1:0]        frames_dropped,
  output logic [FIFO_AW:0]            fifo_level
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int IW    = $clog2(FRAME_LEN);
  localparam int DW    = AXIS_TDATA_WIDTH + 1;

  localparam logic [IW-1:0]    IDX_LAST = IW'(FRAME_LEN - 1);
  localparam logic [FIFO_AW:0] LVL_ADM  = (FIFO_AW + 1)'(DEPTH - FRAME_LEN);
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DROP
  } state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [CNT_WIDTH-1:0]   drop_q, drop_d;
  logic [FIFO_AW:0]       level_q, level_d;
  logic [FIFO_AW:0]       cnt_q, cnt_d;
  logic [FIFO_AW-1:0]     wptr_q, wptr_d;
  logic [FIFO_AW-1:0]     rptr_q, rptr_d;
  logic [DW-1:0]          out_q, out_d;
  logic                   vld_q, vld_d;
  logic [DW-1:0]          mem_q [DEPTH];

  logic wr_en;
  logic wr_last;
  logic pop;
  logic xfer;

  // Admission FSM. level_q counts the output register too, so a frame
  // admitted here is guaranteed room for every one of its samples.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drop_d  = drop_q;
    wr_en   = 1'b0;
    wr_last = 1'b0;
    if (s_axis_tvalid) begin
      unique case (state_q)
        IDLE: begin
          if (enable) begin
            idx_d = IW'(1);
            if (level_q <= LVL_ADM) begin
              wr_en   = 1'b1;
              state_d = PASS;
            end else begin
              state_d = DROP;
              if (drop_q != '1) begin
                drop_d = drop_q + CNT_WIDTH'(1);
              end
            end
          end
        end
        PASS: begin
          wr_en = 1'b1;
          if (idx_q == IDX_LAST) begin
            wr_last = 1'b1;
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        DROP: begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FIFO memory plus a registered first-word-fall-through output stage.
  always_comb begin
    xfer   = vld_q && m_axis_tready;
    pop    = (cnt_q != '0) && (!vld_q || m_axis_tready);
    vld_d  = vld_q;
    out_d  = out_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    level_d = level_q;
    if (pop) begin
      vld_d  = 1'b1;
      out_d  = mem_q[rptr_q];
      rptr_d = rptr_q + FIFO_AW'(1);
    end else if (xfer) begin
      vld_d = 1'b0;
    end
    if (wr_en) begin
      wptr_d = wptr_q + FIFO_AW'(1);
    end
    unique case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + (FIFO_AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (FIFO_AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
    unique case ({wr_en, xfer})
      2'b10:   level_d = level_q + (FIFO_AW + 1)'(1);
      2'b01:   level_d = level_q - (FIFO_AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= {wr_last, s_axis_tdata};
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drop_q  <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!aresetn)
    wr_en |-> (level_q != LVL_FULL));

  assign m_axis_tdata   = out_q[AXIS_TDATA_WIDTH-1:0];
  assign m_axis_tlast   = out_q[AXIS_TDATA_WIDTH];
  assign m_axis_tvalid  = vld_q;
  assign frames_dropped = drop_q;
  assign fifo_level     = level_q;

endmodule

// File: tb/tb_axis_frame_packer.sv
// Bench for axis_frame_packer: FRAME_LEN=4, depth 16.
// Vector table plus hand sequences, checked by a model-fed scoreboard.
module tb_axis_frame_packer;

  localparam int W  = 32;
  localparam int FL = 4;
  localparam int AW = 4;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable = 1'b0;
  logic [W-1:0]  s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic [15:0]   frames_dropped;
  logic [AW:0]   fifo_level;

  axis_frame_packer #(
    .AXIS_TDATA_WIDTH(W),
    .FRAME_LEN(FL),
    .FIFO_AW(AW),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .aresetn(aresetn),
    .enable(enable),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .frames_dropped(frames_dropped),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W:0] sb [$];
  int  m_state = 0;
  int  m_idx = 0;
  int  m_level = 0;
  int  m_drop = 0;
  int  out_n = 0;
  bit  xfer = 1'b0;
  bit  prev_stall = 1'b0;
  logic [W-1:0] pd;
  logic pl;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Reference model, evaluated at each rising edge.
  initial forever begin
    bit wr;
    bit lb;
    @(posedge clk);
    if (!aresetn) begin
      m_state = 0;
      m_idx   = 0;
      m_level = 0;
      m_drop  = 0;
      out_n   = 0;
      sb.delete();
    end else begin
      wr = 1'b0;
      lb = 1'b0;
      if (s_axis_tvalid) begin
        case (m_state)
          0: if (enable) begin
            m_idx = 1;
            if (DP - m_level >= FL) begin
              wr = 1'b1;
              m_state = 1;
            end else begin
              m_state = 2;
              if (m_drop < 65535) m_drop++;
            end
          end
          1: begin
            wr = 1'b1;
            if (m_idx == FL - 1) begin
              lb = 1'b1;
              m_idx = 0;
              m_state = 0;
            end else m_idx++;
          end
          default: begin
            if (m_idx == FL - 1) begin
              m_idx = 0;
              m_state = 0;
            end else m_idx++;
          end
        endcase
      end
      if (wr) sb.push_back({lb, s_axis_tdata});
      m_level = m_level + int'(wr) - int'(xfer);
    end
  end

  // Output monitor, sampled on the falling edge.
  initial forever begin
    logic [W:0] e;
    @(negedge clk);
    xfer = 1'b0;
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      chk("level", fifo_level, m_level);
      chk("drops", frames_dropped, m_drop);
      if (prev_stall)
        chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
            {1'b1, pl, pd});
      if (m_axis_tvalid && m_axis_tready) begin
        xfer = 1'b1;
        if (sb.size() == 0) begin
          chk("unexpected_out", m_axis_tdata, 64'hdead);
        end else begin
          e = sb.pop_front();
          chk("sb_out", {m_axis_tlast, m_axis_tdata}, e);
          chk("tlast_pos", m_axis_tlast, (out_n % FL) == FL - 1);
          out_n++;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata;
      pl = m_axis_tlast;
    end
  end

  task automatic do_reset(input logic rdy);
    @(posedge clk);
    #1;
    aresetn = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    m_axis_tready = rdy;
  endtask

  task automatic send(input logic [W-1:0] d, input logic v,
                      input logic en);
    @(posedge clk);
    #1;
    s_axis_tdata  = d;
    s_axis_tvalid = v;
    enable        = en;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    while ((sb.size() != 0 || m_axis_tvalid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_timeout"}, k >= 200, 0);
    @(negedge clk);
    chk({nm, "_vld0"}, m_axis_tvalid, 0);
    chk({nm, "_lvl0"}, fifo_level, 0);
  endtask

  typedef struct {
    int n;
    bit en;
    int lvl;
    int drop;
  } vec_t;

  vec_t vt [6];

  initial begin
    int n;
    vt[0] = '{20, 1'b1, 16, 1};
    vt[1] = '{24, 1'b1, 16, 2};
    vt[2] = '{16, 1'b1, 16, 0};
    vt[3] = '{17, 1'b1, 16, 1};
    vt[4] = '{6,  1'b0, 0,  0};
    vt[5] = '{12, 1'b1, 12, 0};

    do_reset(1'b0);
    @(negedge clk);
    chk("rst_vld", m_axis_tvalid, 0);
    chk("rst_lvl", fifo_level, 0);
    chk("rst_drop", frames_dropped, 0);
    chk("rst_last", m_axis_tlast, 0);

    // Back-to-back frames with first-output latency.
    do_reset(1'b1);
    send(1, 1'b1, 1'b1);
    send(2, 1'b1, 1'b1);
    @(negedge clk);
    chk("lat_early", m_axis_tvalid, 0);
    send(3, 1'b1, 1'b1);
    @(negedge clk);
    chk("lat_vld", m_axis_tvalid, 1);
    chk("lat_data", m_axis_tdata, 1);
    for (int k = 4; k <= 8; k++) send(k, 1'b1, 1'b1);
    send(0, 1'b0, 1'b1);
    drain("b2b");
    chk("b2b_outs", out_n, 8);
    chk("b2b_drop", frames_dropped, 0);

    // Table: fill with tready low, check level/drops, then drain.
    for (int i = 0; i < 6; i++) begin
      do_reset(1'b0);
      for (int k = 1; k <= vt[i].n; k++)
        send(100 * (i + 1) + k, 1'b1, vt[i].en);
      send(0, 1'b0, vt[i].en);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("vec_level", fifo_level, vt[i].lvl);
      chk("vec_drop", frames_dropped, vt[i].drop);
      drain("vec");
      chk("vec_outs", out_n, vt[i].lvl);
    end

    // Enable dropped mid-frame: the frame still completes.
    do_reset(1'b0);
    send(1, 1'b1, 1'b1);
    send(2, 1'b1, 1'b1);
    for (int k = 3; k <= 6; k++) send(k, 1'b1, 1'b0);
    send(0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("en_level", fifo_level, 4);
    chk("en_drop", frames_dropped, 0);
    drain("en");
    chk("en_outs", out_n, 4);

    // Reset in the middle of a frame.
    do_reset(1'b0);
    send(1, 1'b1, 1'b1);
    send(2, 1'b1, 1'b1);
    send(0, 1'b0, 1'b1);
    @(posedge clk);
    do_reset(1'b1);
    @(negedge clk);
    chk("mrst_vld", m_axis_tvalid, 0);
    chk("mrst_lvl", fifo_level, 0);
    chk("mrst_drop", frames_dropped, 0);
    for (int k = 11; k <= 14; k++) send(k, 1'b1, 1'b1);
    send(0, 1'b0, 1'b1);
    drain("mrst");
    chk("mrst_outs", out_n, 4);

    // Random ready and input gaps.
    do_reset(1'b0);
    n = 0;
    while (n < 1000) begin
      @(posedge clk);
      #1;
      enable = 1'b1;
      m_axis_tready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 5000 + n;
        n++;
      end else begin
        s_axis_tvalid = 1'b0;
      end
    end
    send(0, 1'b0, 1'b1);
    drain("rand");
    chk("rand_frames", out_n % FL, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
